// File: rtl/mbc_memory_unit_pkg.sv
// Shared address map, region tags and MBC register layout for the banked memory unit.
package mbc_memory_unit_pkg;

  localparam logic [15:0] ROMX_BASE   = 16'h4000;
  localparam logic [15:0] VRAM_BASE   = 16'h8000;
  localparam logic [15:0] EXT_BASE    = 16'hA000;
  localparam logic [15:0] WRAM_BASE   = 16'hC000;
  localparam logic [15:0] ECHO_BASE   = 16'hE000;
  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam logic [15:0] UNUSED_BASE = 16'hFEA0;
  localparam logic [15:0] HRAM_BASE   = 16'hFF80;
  localparam logic [15:0] IE_ADDR     = 16'hFFFF;

  typedef enum logic [2:0] {
    REG_ROM0,
    REG_ROMX,
    REG_VRAM,
    REG_EXT,
    REG_WRAM,
    REG_OAM,
    REG_HRAM,
    REG_OPEN
  } mem_region_t;

  typedef struct packed {
    logic       ram_en;
    logic [1:0] rom_hi;
    logic [4:0] rom_lo;
    logic       mode;
  } mbc_regs_t;

  localparam mbc_regs_t MBC_RESET = '{ram_en: 1'b0, rom_hi: 2'd0, rom_lo: 5'd1, mode: 1'b0};

  // Echo RAM folds onto WRAM; unusable, IO and IE addresses fall to REG_OPEN.
  function automatic mem_region_t decode_region(input logic [15:0] a);
    mem_region_t r;
    r = REG_OPEN;
    if (a < ROMX_BASE)        r = REG_ROM0;
    else if (a < VRAM_BASE)   r = REG_ROMX;
    else if (a < EXT_BASE)    r = REG_VRAM;
    else if (a < WRAM_BASE)   r = REG_EXT;
    else if (a < ECHO_BASE)   r = REG_WRAM;
    else if (a < OAM_BASE)    r = REG_WRAM;
    else if (a < UNUSED_BASE) r = REG_OAM;
    else if (a < HRAM_BASE)   r = REG_OPEN;
    else if (a != IE_ADDR)    r = REG_HRAM;
    return r;
  endfunction

endpackage

// File: rtl/mbc_memory_unit_ram.sv
// Single-port byte RAM with registered read; read data holds when en is low.
module sync_ram_bank #(
  parameter int unsigned DEPTH = 8192,
  parameter string       INIT  = "",
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q, rdata_d;

  // capture a new read only on an enabled cycle
  always_comb begin
    rdata_d = en ? mem[addr] : rdata_q;
  end

  // array write and read-data register
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mbc_memory_unit.sv
// MBC1-style banked memory unit: address decode, bank registers and registered read mux.
module mbc_memory_unit
  import mbc_memory_unit_pkg::*;
#(
  parameter int unsigned ROM_BANKS = 4,
  parameter int unsigned RAM_BANKS = 4,
  parameter string       ROM_INIT  = "ROM.hex",
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic [6:0]  rom_bank,
  output logic [1:0]  ram_bank,
  output logic        ram_en
);

  localparam int unsigned ROM_AW   = $clog2(ROM_BANKS) + 14;
  localparam int unsigned RAM_AW   = $clog2(RAM_BANKS) + 13;
  localparam logic [6:0]  ROM_MASK = 7'(ROM_BANKS - 1);
  localparam logic [1:0]  RAM_MASK = 2'(RAM_BANKS - 1);

  mbc_regs_t   regs_q, regs_d;
  mem_region_t region, rd_region, region_q, region_d;
  logic        rvalid_q, rvalid_d;
  logic        rd, wr;
  logic [6:0]  rom0_bank, romx_bank, rom_sel;
  logic [1:0]  ext_bank;
  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ext_addr;
  logic [7:0]  rom_rd, vram_rd, ext_rd, wram_rd, oam_rd, hram_rd;

  // MBC register writes from the 0x0000-0x7FFF window
  always_comb begin
    regs_d = regs_q;
    if (req && we) begin
      case (addr[15:13])
        3'd0:    regs_d.ram_en = (wdata[3:0] == 4'hA);
        3'd1:    regs_d.rom_lo = (wdata[4:0] == 5'd0) ? 5'd1 : wdata[4:0];
        3'd2:    regs_d.rom_hi = wdata[1:0];
        3'd3:    regs_d.mode   = wdata[0];
        default: ;
      endcase
    end
  end

  // decode, effective banks and array addresses from the current bank registers
  always_comb begin
    rd        = req && !we;
    wr        = req && we;
    region    = decode_region(addr);
    rd_region = region;
    if (region == REG_EXT && !regs_q.ram_en) rd_region = REG_OPEN;
    romx_bank = {regs_q.rom_hi, regs_q.rom_lo} & ROM_MASK;
    rom0_bank = regs_q.mode ? ({regs_q.rom_hi, 5'd0} & ROM_MASK) : 7'd0;
    ext_bank  = regs_q.mode ? (regs_q.rom_hi & RAM_MASK) : 2'd0;
    rom_sel   = (region == REG_ROM0) ? rom0_bank : romx_bank;
    rom_addr  = ROM_AW'({rom_sel, addr[13:0]});
    ext_addr  = RAM_AW'({ext_bank, addr[12:0]});
    region_d  = rd ? rd_region : region_q;
    rvalid_d  = rd;
  end

  // bank registers and read pipeline; array writes are not gated by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q   <= MBC_RESET;
      region_q <= REG_OPEN;
      rvalid_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      region_q <= region_d;
      rvalid_q <= rvalid_d;
    end
  end

  sync_ram_bank #(.DEPTH(ROM_BANKS * 16384), .INIT(ROM_INIT)) u_rom (
    .clk(clk), .en(rd && (rd_region == REG_ROM0 || rd_region == REG_ROMX)),
    .we(1'b0), .addr(rom_addr), .wdata(8'h00), .rdata(rom_rd));

  sync_ram_bank #(.DEPTH(8192)) u_vram (
    .clk(clk), .en(rd && rd_region == REG_VRAM), .we(wr && region == REG_VRAM),
    .addr(addr[12:0]), .wdata(wdata), .rdata(vram_rd));

  sync_ram_bank #(.DEPTH(RAM_BANKS * 8192)) u_ext (
    .clk(clk), .en(rd && rd_region == REG_EXT),
    .we(wr && region == REG_EXT && regs_q.ram_en),
    .addr(ext_addr), .wdata(wdata), .rdata(ext_rd));

  sync_ram_bank #(.DEPTH(8192)) u_wram (
    .clk(clk), .en(rd && rd_region == REG_WRAM), .we(wr && region == REG_WRAM),
    .addr(addr[12:0]), .wdata(wdata), .rdata(wram_rd));

  sync_ram_bank #(.DEPTH(160)) u_oam (
    .clk(clk), .en(rd && rd_region == REG_OAM), .we(wr && region == REG_OAM),
    .addr(addr[7:0]), .wdata(wdata), .rdata(oam_rd));

  sync_ram_bank #(.DEPTH(128)) u_hram (
    .clk(clk), .en(rd && rd_region == REG_HRAM), .we(wr && region == REG_HRAM),
    .addr(addr[6:0]), .wdata(wdata), .rdata(hram_rd));

  // read data selected by the region tag registered with the request
  always_comb begin
    case (region_q)
      REG_ROM0, REG_ROMX: rdata = rom_rd;
      REG_VRAM:           rdata = vram_rd;
      REG_EXT:            rdata = ext_rd;
      REG_WRAM:           rdata = wram_rd;
      REG_OAM:            rdata = oam_rd;
      REG_HRAM:           rdata = hram_rd;
      default:            rdata = OPEN_BUS;
    endcase
  end

  assign rvalid   = rvalid_q;
  assign rom_bank = romx_bank;
  assign ram_bank = ext_bank;
  assign ram_en   = regs_q.ram_en;

endmodule
